// File: rtl/load_store_unit.sv
// MIPS load/store front end for a big-endian, word-wide data memory.
// Sub-word loads are extracted and extended; sub-word stores are read-modify-write.
module load_store_unit #(
  parameter int unsigned ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_adress,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_read_data
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_uns;
  logic [1:0]          r_off;
  logic [15:0]         r_wdata;
  logic                r_ready;
  logic                r_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic [ADDR_W-1:0]   r_mem_adress;
  logic [DATA_W-1:0]   r_mem_write_data;
  logic                r_mem_read;
  logic                r_mem_write;

  logic                w_accept;
  logic                w_misalign;
  logic [4:0]          w_bsh;
  logic [4:0]          w_hsh;
  logic [7:0]          w_lbyte;
  logic [15:0]         w_lhalf;
  logic [DATA_W-1:0]   w_load;
  logic [DATA_W-1:0]   w_bmask;
  logic [DATA_W-1:0]   w_hmask;
  logic [DATA_W-1:0]   w_merged;

  assign w_accept   = req & r_ready;
  assign w_misalign = (size == 2'b11) ||
                      (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);

  // Big-endian lane positions: offset 0 is the most significant byte.
  assign w_bsh   = 5'd24 - {r_off, 3'b000};
  assign w_hsh   = 5'd16 - {r_off[1], 4'b0000};
  assign w_lbyte = mem_read_data[5'd31 - {r_off, 3'b000} -: 8];
  assign w_lhalf = mem_read_data[5'd31 - {r_off[1], 4'b0000} -: 16];
  assign w_bmask = DATA_W'(32'h0000_00FF) << w_bsh;
  assign w_hmask = DATA_W'(32'h0000_FFFF) << w_hsh;

  // Load extraction and store merge from the returned memory word
  always_comb begin
    w_load   = mem_read_data;
    w_merged = mem_read_data;
    case (r_size)
      2'b00: begin
        w_load   = {{24{~r_uns & w_lbyte[7]}}, w_lbyte};
        w_merged = (mem_read_data & ~w_bmask) |
                   ((DATA_W'(r_wdata[7:0]) << w_bsh) & w_bmask);
      end
      2'b01: begin
        w_load   = {{16{~r_uns & w_lhalf[15]}}, w_lhalf};
        w_merged = (mem_read_data & ~w_hmask) |
                   ((DATA_W'(r_wdata) << w_hsh) & w_hmask);
      end
      default: begin
        w_load   = mem_read_data;
        w_merged = mem_read_data;
      end
    endcase
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misalign)                 w_next = S_RESP;
          else if (we && size == 2'b10)   w_next = S_WR;
          else                            w_next = S_RD_REQ;
        end
      end
      S_RD_REQ:  w_next = S_RD_WAIT;
      S_RD_WAIT: w_next = r_we ? S_WR : S_RESP;
      S_WR:      w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_we             <= 1'b0;
      r_size           <= 2'b00;
      r_uns            <= 1'b0;
      r_off            <= 2'b00;
      r_wdata          <= 16'h0;
      r_ready          <= 1'b1;
      r_done           <= 1'b0;
      r_err            <= 1'b0;
      r_rdata          <= '0;
      r_mem_adress     <= '0;
      r_mem_write_data <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ready     <= (w_next == S_IDLE);
      r_done      <= (w_next == S_RESP);
      r_mem_read  <= (w_next == S_RD_REQ);
      r_mem_write <= (w_next == S_WR);
      if (r_state == S_IDLE && w_accept) begin
        r_we         <= we;
        r_size       <= size;
        r_uns        <= uns;
        r_off        <= addr[1:0];
        r_wdata      <= wdata[15:0];
        r_err        <= w_misalign;
        r_mem_adress <= {addr[ADDR_W-1:2], 2'b00};
        if (we && size == 2'b10) r_mem_write_data <= wdata;
      end
      if (r_state == S_RD_WAIT) begin
        if (r_we) r_mem_write_data <= w_merged;
        else      r_rdata          <= w_load;
      end
    end
  end

  assign ready          = r_ready;
  assign done           = r_done;
  assign err            = r_err;
  assign rdata          = r_rdata;
  assign mem_adress     = r_mem_adress;
  assign mem_write_data = r_mem_write_data;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a big-endian word memory model
// (posedge-registered reads, negedge writes).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [17:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [17:0] mem_adress;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data = 32'h0;

  load_store_unit #(.ADDR_W(18)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_adress(mem_adress), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic        err;
    logic [31:0] rdata;
    logic [17:0] adr;
    int          cyc;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] mem [0:65535];
  logic [31:0] model [int];
  int          cyc = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          wr_cyc = -1;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_read) begin
      mem_read_data <= mem[mem_adress[17:2]];
      n_rd = n_rd + 1;
    end
  end

  always @(negedge clk) begin
    if (mem_write) begin
      mem[mem_adress[17:2]] <= mem_write_data;
      n_wr   = n_wr + 1;
      wr_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] sz,
                                     input logic u, input logic [1:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    case (o)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = o[1] ? w[15:0] : w[31:16];
    if (sz == 2'b00) return u ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'b01) return u ? {16'h0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                        input logic [1:0] o, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (o)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end else if (sz == 2'b01) begin
      if (o[1]) r[15:0]  = d[15:0];
      else      r[31:16] = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("err", {31'b0, err}, {31'b0, e.err});
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("mem_adress", 32'(mem_adress), 32'(e.adr));
        if (e.is_load && !e.err) check("rdata", rdata, e.rdata);
      end
    end
  end

  task automatic preload(input logic [17:0] a, input logic [31:0] w);
    mem[a[17:2]]        = w;
    model[int'(a[17:2])] = w;
  endtask

  function automatic logic misal(input logic [1:0] sz, input logic [17:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  // Build and queue the expectation for a request accepted at the next posedge
  task automatic expect_req(input logic iw, input logic [1:0] isz, input logic iu,
                            input logic [17:0] ia, input logic [31:0] id, input int acc);
    sb_t  e;
    logic m;
    int   k;
    m = misal(isz, ia);
    k = int'(ia[17:2]);
    e.is_load = !iw;
    e.err     = m;
    e.adr     = {ia[17:2], 2'b00};
    e.rdata   = 32'h0;
    e.cyc     = acc + (m ? 0 : (iw ? (isz == 2'b10 ? 1 : 3) : 2));
    if (!m && iw)  model[k] = merge(model[k], isz, ia[1:0], id);
    if (!m && !iw) e.rdata  = ext(model[k], isz, iu, ia[1:0]);
    sb.push_back(e);
  endtask

  task automatic drive(input logic iw, input logic [1:0] isz, input logic iu,
                       input logic [17:0] ia, input logic [31:0] id);
    req = 1'b1; we = iw; size = isz; uns = iu; addr = ia; wdata = id;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); #1; n++; end
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic iw, input logic [1:0] isz, input logic iu,
                       input logic [17:0] ia, input logic [31:0] id);
    int   acc, rd0, wr0;
    logic m;
    wait_ready();
    m   = misal(isz, ia);
    acc = cyc + 1;
    rd0 = n_rd;
    wr0 = n_wr;
    expect_req(iw, isz, iu, ia, id, acc);
    drive(iw, isz, iu, ia, id);
    @(negedge clk); #1;
    req = 1'b0;
    wait_drain();
    @(negedge clk); #1;
    check("done_pulse", {31'b0, done}, 32'd0);
    check("ready_back", {31'b0, ready}, 32'd1);
    check("n_write", 32'(n_wr - wr0), (iw && !m) ? 32'd1 : 32'd0);
    check("n_read", 32'(n_rd - rd0), (!m && !(iw && isz == 2'b10)) ? 32'd1 : 32'd0);
    if (iw && !m) check("write_cycle", 32'(wr_cyc), 32'(acc + (isz == 2'b10 ? 0 : 2)));
  endtask

  task automatic chk_reset_state(input string pfx);
    check({pfx, "_ready"},  {31'b0, ready},     32'd1);
    check({pfx, "_done"},   {31'b0, done},      32'd0);
    check({pfx, "_err"},    {31'b0, err},       32'd0);
    check({pfx, "_mrd"},    {31'b0, mem_read},  32'd0);
    check({pfx, "_mwr"},    {31'b0, mem_write}, 32'd0);
    check({pfx, "_rdata"},  rdata,              32'd0);
    check({pfx, "_madr"},   32'(mem_adress),    32'd0);
    check({pfx, "_mwdata"}, mem_write_data,     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, wr0;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 18'h0; wdata = 32'h0;
    preload(18'h010, 32'h11223344);
    preload(18'h020, 32'h80FF7F01);
    preload(18'h030, 32'hAABBCCDD);
    preload(18'h040, 32'h01020304);
    preload(18'h050, 32'hCAFEBABE);
    preload(18'h060, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk_reset_state("reset");
    reset = 1'b0;
    @(negedge clk); #1;

    // Word and sub-word loads with both extensions
    issue(1'b0, 2'b10, 1'b0, 18'h010, 32'h0);
    check("lw_const", rdata, 32'h11223344);
    issue(1'b0, 2'b00, 1'b0, 18'h021, 32'h0);
    check("lb_const", rdata, 32'hFFFFFFFF);
    issue(1'b0, 2'b00, 1'b1, 18'h021, 32'h0);
    check("lbu_const", rdata, 32'h000000FF);
    issue(1'b0, 2'b01, 1'b0, 18'h022, 32'h0);
    check("lh_const", rdata, 32'h00007F01);
    issue(1'b0, 2'b00, 1'b0, 18'h020, 32'h0);
    check("lb0_const", rdata, 32'hFFFFFF80);
    issue(1'b0, 2'b01, 1'b0, 18'h020, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 18'h020, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 18'h023, 32'h0);
    issue(1'b0, 2'b10, 1'b1, 18'h020, 32'h0);

    // Sub-word stores through read-modify-write
    issue(1'b1, 2'b00, 1'b0, 18'h032, 32'h12345678);
    check("sb_mem", mem[18'h030 >> 2], 32'hAABB78DD);
    issue(1'b0, 2'b10, 1'b0, 18'h030, 32'h0);
    check("sb_lw_const", rdata, 32'hAABB78DD);
    issue(1'b1, 2'b01, 1'b0, 18'h030, 32'h0000BEEF);
    issue(1'b1, 2'b00, 1'b0, 18'h043, 32'hFFFFFF9A);
    issue(1'b1, 2'b00, 1'b0, 18'h040, 32'h00000055);
    issue(1'b0, 2'b10, 1'b0, 18'h040, 32'h0);
    check("sb_edges_mem", mem[18'h040 >> 2], 32'h5502039A);
    issue(1'b0, 2'b10, 1'b0, 18'h030, 32'h0);

    // Misaligned and reserved-size requests never reach memory
    issue(1'b1, 2'b01, 1'b0, 18'h041, 32'h0000FFFF);
    issue(1'b0, 2'b10, 1'b0, 18'h042, 32'h0);
    check("err_rdata_held", rdata, 32'hBEEF78DD);
    issue(1'b0, 2'b11, 1'b0, 18'h044, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 18'h046, 32'h0);
    check("err_mem_intact", mem[18'h040 >> 2], 32'h5502039A);
    issue(1'b0, 2'b10, 1'b0, 18'h010, 32'h0);

    // Word store with req held high into a load of the same address
    wait_ready();
    acc = cyc + 1;
    expect_req(1'b1, 2'b10, 1'b0, 18'h060, 32'hDEADBEEF, acc);
    expect_req(1'b0, 2'b10, 1'b0, 18'h060, 32'h0, acc + 3);
    drive(1'b1, 2'b10, 1'b0, 18'h060, 32'hDEADBEEF);
    @(negedge clk); #1;
    drive(1'b0, 2'b10, 1'b0, 18'h060, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    req = 1'b0;
    wait_drain();
    check("b2b_rdata", rdata, 32'hDEADBEEF);

    // Reset during RD_WAIT of a halfword store
    @(negedge clk); #1;
    wait_ready();
    wr0 = n_wr;
    drive(1'b1, 2'b01, 1'b0, 18'h052, 32'h00001234);
    @(negedge clk); #1;
    req = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    chk_reset_state("midrst");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("midrst_nowrite", 32'(n_wr - wr0), 32'd0);
    check("midrst_mem", mem[18'h050 >> 2], 32'hCAFEBABE);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);
    issue(1'b0, 2'b01, 1'b0, 18'h052, 32'h0);
    check("post_rst_lh", rdata, 32'hFFFFBABE);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
